// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline encodings for the hazard/stall controller.
// Destination select, write-back source and stall FSM state.
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] REGDST_RD = 2'd0;
    localparam logic [1:0] REGDST_RT = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;
    localparam logic [1:0] REGDST_K0 = 2'd3;

    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [4:0] REG_K0 = 5'd26;

    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC4 = 2'd2;

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    function automatic logic src_hit(
        input logic       use_src,
        input logic [4:0] src,
        input logic [4:0] dest,
        input logic       wr
    );
        return use_src && (src != 5'd0) && wr && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_dest_reg_sel.sv
// Decodes a stage's written register from RegDst.
// o_Wr is low for $0 so $0 never creates a hazard.
module dest_reg_sel
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [4:0] i_Rd,
    input  logic [4:0] i_Rt,
    input  logic [1:0] i_RegDst,
    input  logic       i_RegWr,
    output logic [4:0] o_Dest,
    output logic       o_Wr
);

    always_comb begin
        o_Dest = i_Rd;
        case (i_RegDst)
            REGDST_RD: o_Dest = i_Rd;
            REGDST_RT: o_Dest = i_Rt;
            REGDST_RA: o_Dest = REG_RA;
            REGDST_K0: o_Dest = REG_K0;
            default:   o_Dest = i_Rd;
        endcase
    end

    assign o_Wr = i_RegWr && (o_Dest != 5'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-operand stall control with flush and IRQ accept.
// Stall outputs are combinational; STALL state covers the second cycle.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        ID_Branch,
    input  logic        ID_Redirect,
    input  logic [4:0]  EX_Rd,
    input  logic [4:0]  EX_Rt,
    input  logic [1:0]  EX_RegDst,
    input  logic        EX_RegWr,
    input  logic [1:0]  EX_MemToReg,
    input  logic [4:0]  MEM_Rd,
    input  logic [4:0]  MEM_Rt,
    input  logic [1:0]  MEM_RegDst,
    input  logic        MEM_RegWr,
    input  logic [1:0]  MEM_MemToReg,
    input  logic        IRQ,
    output logic        PC_Wr,
    output logic        IF_ID_Wr,
    output logic        ID_EX_Bubble,
    output logic        IF_ID_Flush,
    output logic        IRQ_Take,
    output logic [31:0] StallCount
);

    logic [4:0]  w_ex_dest;
    logic        w_ex_wr;
    logic [4:0]  w_mem_dest;
    logic        w_mem_wr;
    logic        w_ex_hit;
    logic        w_mem_hit;
    logic [1:0]  w_need;
    logic        w_stall;
    logic        w_take;
    logic        w_flush;
    state_t      r_state;
    state_t      w_state_nx;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nx;
    logic        r_pend;
    logic [31:0] r_stall_cnt;

    dest_reg_sel u_ex_dest (
        .i_Rd     (EX_Rd),
        .i_Rt     (EX_Rt),
        .i_RegDst (EX_RegDst),
        .i_RegWr  (EX_RegWr),
        .o_Dest   (w_ex_dest),
        .o_Wr     (w_ex_wr)
    );

    dest_reg_sel u_mem_dest (
        .i_Rd     (MEM_Rd),
        .i_Rt     (MEM_Rt),
        .i_RegDst (MEM_RegDst),
        .i_RegWr  (MEM_RegWr),
        .o_Dest   (w_mem_dest),
        .o_Wr     (w_mem_wr)
    );

    assign w_ex_hit =
        src_hit(ID_UseRs, ID_Rs, w_ex_dest, w_ex_wr) ||
        src_hit(ID_UseRt, ID_Rt, w_ex_dest, w_ex_wr);

    assign w_mem_hit =
        src_hit(ID_UseRs, ID_Rs, w_mem_dest, w_mem_wr) ||
        src_hit(ID_UseRt, ID_Rt, w_mem_dest, w_mem_wr);

    // PC4 producers forward from the pipe, so they never stall
    always_comb begin
        w_need = 2'd0;
        if (w_ex_hit && EX_MemToReg == M2R_MEM) begin
            w_need = ID_Branch ? 2'd2 : 2'd1;
        end else if (ID_Branch && w_ex_hit && EX_MemToReg == M2R_ALU) begin
            w_need = 2'd1;
        end
        if (ID_Branch && w_mem_hit && MEM_MemToReg == M2R_MEM &&
            w_need == 2'd0) begin
            w_need = 2'd1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_stall    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = (w_need != 2'd0);
                if (w_need == 2'd2) begin
                    w_state_nx = ST_STALL;
                    w_cnt_nx   = 2'd1;
                end
            end
            ST_STALL: begin
                w_stall  = 1'b1;
                w_cnt_nx = r_cnt - 2'd1;
                if (w_cnt_nx == 2'd0) begin
                    w_state_nx = ST_RUN;
                end
            end
            default: begin
                w_state_nx = ST_RUN;
                w_cnt_nx   = 2'd0;
            end
        endcase
        if (reset) begin
            w_stall = 1'b0;
        end
    end

    assign w_flush = ID_Redirect && !w_stall && !reset;
    assign w_take  = r_pend && (r_state == ST_RUN) && !w_stall &&
                     !w_flush && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= 2'd0;
            r_pend      <= 1'b0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (w_take) begin
                r_pend <= 1'b0;
            end else if (IRQ) begin
                r_pend <= 1'b1;
            end
            if (w_stall && r_stall_cnt != 32'hFFFF_FFFF) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign PC_Wr        = !w_stall;
    assign IF_ID_Wr     = !w_stall;
    assign ID_EX_Bubble = w_stall;
    assign IF_ID_Flush  = w_flush;
    assign IRQ_Take     = w_take;
    assign StallCount   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed checks for hazard_stall_ctrl.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_Rs, ID_Rt;
    logic        ID_UseRs, ID_UseRt, ID_Branch, ID_Redirect;
    logic [4:0]  EX_Rd, EX_Rt;
    logic [1:0]  EX_RegDst, EX_MemToReg;
    logic        EX_RegWr;
    logic [4:0]  MEM_Rd, MEM_Rt;
    logic [1:0]  MEM_RegDst, MEM_MemToReg;
    logic        MEM_RegWr;
    logic        IRQ;
    logic        PC_Wr, IF_ID_Wr, ID_EX_Bubble, IF_ID_Flush, IRQ_Take;
    logic [31:0] StallCount;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UseRs     (ID_UseRs),
        .ID_UseRt     (ID_UseRt),
        .ID_Branch    (ID_Branch),
        .ID_Redirect  (ID_Redirect),
        .EX_Rd        (EX_Rd),
        .EX_Rt        (EX_Rt),
        .EX_RegDst    (EX_RegDst),
        .EX_RegWr     (EX_RegWr),
        .EX_MemToReg  (EX_MemToReg),
        .MEM_Rd       (MEM_Rd),
        .MEM_Rt       (MEM_Rt),
        .MEM_RegDst   (MEM_RegDst),
        .MEM_RegWr    (MEM_RegWr),
        .MEM_MemToReg (MEM_MemToReg),
        .IRQ          (IRQ),
        .PC_Wr        (PC_Wr),
        .IF_ID_Wr     (IF_ID_Wr),
        .ID_EX_Bubble (ID_EX_Bubble),
        .IF_ID_Flush  (IF_ID_Flush),
        .IRQ_Take     (IRQ_Take),
        .StallCount   (StallCount)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        ID_Rs = 0; ID_Rt = 0; ID_UseRs = 0; ID_UseRt = 0;
        ID_Branch = 0; ID_Redirect = 0;
        EX_Rd = 0; EX_Rt = 0; EX_RegDst = 0; EX_RegWr = 0;
        EX_MemToReg = 0;
        MEM_Rd = 0; MEM_Rt = 0; MEM_RegDst = 0; MEM_RegWr = 0;
        MEM_MemToReg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_lw8();
        EX_RegDst = 2'd1; EX_Rt = 5'd8; EX_RegWr = 1;
        EX_MemToReg = 2'd1;
    endtask

    initial begin
        reset = 1; IRQ = 0;
        clr_in();
        tick();
        // hazard and redirect present while reset is held
        ex_lw8(); ID_Rs = 8; ID_UseRs = 1; ID_Redirect = 1; IRQ = 1;
        #1;
        chk("rst_pcwr", PC_Wr, 1);
        chk("rst_ifidwr", IF_ID_Wr, 1);
        chk("rst_bubble", ID_EX_Bubble, 0);
        chk("rst_flush", IF_ID_Flush, 0);
        chk("rst_take", IRQ_Take, 0);
        tick();
        chk("rst_cnt", StallCount, 0);
        reset = 0; IRQ = 0;
        clr_in();
        tick();
        chk("idle_pcwr", PC_Wr, 1);
        chk("idle_take", IRQ_Take, 0);

        // load-use: one stall
        ex_lw8(); ID_Rs = 8; ID_UseRs = 1;
        #1;
        chk("lu_pcwr", PC_Wr, 0);
        chk("lu_ifidwr", IF_ID_Wr, 0);
        chk("lu_bubble", ID_EX_Bubble, 1);
        tick();
        EX_RegWr = 0; EX_MemToReg = 0;
        #1;
        chk("lu_resume", PC_Wr, 1);
        chk("lu_nobub", ID_EX_Bubble, 0);
        chk("lu_cnt", StallCount, 1);

        // load-branch with redirect, IRQ pulse in stall cycle 1
        clr_in();
        ex_lw8(); ID_Rs = 8; ID_UseRs = 1; ID_Branch = 1;
        ID_Redirect = 1; IRQ = 1;
        #1;
        chk("lb1_pcwr", PC_Wr, 0);
        chk("lb1_flush", IF_ID_Flush, 0);
        chk("lb1_take", IRQ_Take, 0);
        tick();
        IRQ = 0;
        EX_RegWr = 0; EX_MemToReg = 0;
        #1;
        chk("lb2_pcwr", PC_Wr, 0);
        chk("lb2_bubble", ID_EX_Bubble, 1);
        chk("lb2_flush", IF_ID_Flush, 0);
        chk("lb2_take", IRQ_Take, 0);
        tick();
        chk("lb3_pcwr", PC_Wr, 1);
        chk("lb3_flush", IF_ID_Flush, 1);
        chk("lb3_take", IRQ_Take, 0);
        chk("lb3_cnt", StallCount, 3);
        tick();
        clr_in(); IRQ = 1;
        #1;
        chk("irq_take", IRQ_Take, 1);
        tick();
        IRQ = 0;
        #1;
        chk("irq_norearm", IRQ_Take, 0);
        tick();
        chk("irq_quiet", IRQ_Take, 0);

        // jal in EX, jr $31 in ID
        EX_RegDst = 2'd2; EX_RegWr = 1; EX_MemToReg = 2'd2; EX_Rd = 5;
        ID_Branch = 1; ID_Rs = 31; ID_UseRs = 1;
        #1;
        chk("jal_jr", PC_Wr, 1);
        tick();
        clr_in();
        EX_RegWr = 1; EX_MemToReg = 1; ID_UseRs = 1; ID_UseRt = 1;
        ID_Branch = 1;
        #1;
        chk("zero_reg", PC_Wr, 1);
        tick();

        // ALU result to $k0 feeding a branch Rt
        clr_in();
        EX_RegDst = 2'd3; EX_RegWr = 1; ID_Branch = 1;
        ID_Rt = 26; ID_UseRt = 1;
        #1;
        chk("k0_br", PC_Wr, 0);
        ID_Branch = 0;
        #1;
        chk("k0_alu", PC_Wr, 1);
        ID_Branch = 1; ID_UseRt = 0;
        #1;
        chk("k0_unused", PC_Wr, 1);
        ID_UseRt = 1; EX_RegWr = 0;
        #1;
        chk("k0_nowr", PC_Wr, 1);
        tick();

        // load in MEM feeding a branch
        clr_in();
        MEM_Rd = 5; MEM_RegWr = 1; MEM_MemToReg = 1;
        ID_Rs = 5; ID_UseRs = 1; ID_Branch = 1;
        #1;
        chk("mem_br", PC_Wr, 0);
        ID_Branch = 0;
        #1;
        chk("mem_alu", PC_Wr, 1);
        tick();

        // reset in stall cycle 1 aborts the stall
        clr_in();
        ex_lw8(); ID_Rs = 8; ID_UseRs = 1; ID_Branch = 1;
        #1;
        chk("rs1_pcwr", PC_Wr, 0);
        tick();
        reset = 1;
        clr_in();
        #1;
        chk("rs2_pcwr", PC_Wr, 1);
        tick();
        reset = 0;
        #1;
        chk("rs3_pcwr", PC_Wr, 1);
        chk("rs3_bubble", ID_EX_Bubble, 0);
        chk("rs3_cnt", StallCount, 0);
        tick();
        chk("rs4_pcwr", PC_Wr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have ports: ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports: ID_UseRs, ID_UseRt  in  1 each  ID instruction reads Rs / Rt.
REQ-005 SHALL have port: ID_Branch  in  1  ID holds a branch or jr/jalr resolved in ID (operands via ahead-branch forwarding).
REQ-006 SHALL have port: ID_Redirect  in  1  ID branch taken or jump; valid only when ID is not stalled.
REQ-007 SHALL have ports: EX_Rd, EX_Rt  in  5; EX_RegDst  in  2; EX_RegWr  in  1; EX_MemToReg  in  2  EX-stage destination info.
REQ-008 SHALL have ports: MEM_Rd, MEM_Rt  in  5; MEM_RegDst  in  2; MEM_RegWr  in  1; MEM_MemToReg  in  2  MEM-stage destination info.
REQ-009 SHALL have port: IRQ  in  1  level interrupt request.
REQ-010 SHALL have outputs: PC_Wr, IF_ID_Wr  out  1  hold PC and IF/ID when 0.
REQ-011 SHALL have outputs: ID_EX_Bubble, IF_ID_Flush  out  1  insert a nop into ID/EX; squash IF/ID.
REQ-012 SHALL have outputs: IRQ_Take  out  1  one-cycle interrupt accept pulse; StallCount  out  32  saturating stall-cycle counter.

Function
REQ-013 Destination decode SHALL be: RegDst 0 -> Rd, 1 -> Rt, 2 -> 31, 3 -> 26; never a hazard when the matched source is 0 or RegWr=0.
REQ-014 A source matches a stage SHALL mean: source used, source != 0, and source == that stage's destination.
REQ-015 The required stall count N SHALL be the maximum of the following; N=0 if none apply:
  - EX MemToReg=1 matching any used source: N=1, or N=2 when ID_Branch=1.
  - ID_Branch with EX MemToReg=0 match: N=1.
  - ID_Branch with MEM MemToReg=1 match: N=1.
  - MemToReg=2 (PC_4): no stall.
REQ-016 FSM states SHALL be RUN and STALL, plus a 2-bit remaining-count register.
REQ-017 In RUN with N>0 the block SHALL, combinationally in that cycle, drive PC_Wr=0, IF_ID_Wr=0 and ID_EX_Bubble=1.
  - If N=2, it SHALL enter STALL with count=1.
  - If N=1, it SHALL stay in RUN; the hazard re-evaluates next cycle.
REQ-018 In STALL the block SHALL force a stall regardless of detection, decrement count, and return to RUN when count reaches 0 (total stalls = N).
REQ-019 IF_ID_Flush SHALL equal ID_Redirect and not stalling; a stall suppresses flush in the same cycle.
REQ-020 IRQ high SHALL set a pending flag.
  - IRQ_Take=1 for exactly one cycle when pending, in RUN, and no stall or flush that cycle; pending clears on that cycle's edge.
  - IRQ high during the take cycle SHALL not re-arm pending.
REQ-021 StallCount SHALL increment each cycle PC_Wr=0 and saturate at 0xFFFF_FFFF.
REQ-022 Outputs other than IRQ_Take and StallCount SHALL be combinational from inputs and state; there is no extra latency.

Reset
REQ-023 On reset the block SHALL enter RUN with count=0, pending=0 and StallCount=0.
REQ-024 In the reset cycle the block SHALL drive PC_Wr=1, IF_ID_Wr=1, ID_EX_Bubble=0, IF_ID_Flush=0 and IRQ_Take=0.
REQ-025 Reset during STALL SHALL abort the stall immediately, with no residual stall cycle after release.

Structure
REQ-026 Shared pipeline package SHALL hold:
  - RegDst encodings (RD, RT, RA=31, K0=26);
  - MemToReg encodings (ALU=0, MEM=1, PC4=2);
  - FSM state typedef.
REQ-027 Destination decode SHALL be one sub-module, dest_reg_sel, instantiated for EX and MEM.

Verification
REQ-028 Load-use: EX lw, EX_RegDst=1, EX_Rt=8, EX_MemToReg=1; ID add uses Rs=8 -> exactly 1 cycle of PC_Wr=0 with Bubble=1, then resume.
REQ-029 Load-branch: same EX lw to $8, ID beq with ID_Branch=1 using $8 -> 2 stall cycles (RUN->STALL->RUN), StallCount += 2.
REQ-030 No-stall cases:
  - EX jal (RegDst=2, MemToReg=2), ID jr $31 -> 0 stalls.
  - EX writes $0 with ID using $0 -> 0 stalls.
REQ-031 Redirect under stall: ID_Redirect=1 during a load-branch stall -> IF_ID_Flush=0 while stalled, then 1 in the first unstalled cycle.
REQ-032 IRQ:
  - IRQ pulse during a 2-cycle stall -> IRQ_Take pulses once, in the first clean RUN cycle.
  - reset asserted in STALL cycle 1 -> no stall the next cycle and StallCount=0.
